psum_spad_ctrl: RTL and testbench
=================================

Name: psum_spad_ctrl

Overview:
- Partial-sum scratchpad and sequencer on the psum side of a single macc PE.
- Supplies the PE's internal_psum and clear inputs, captures the PE's 40-bit accum_out, saturates it to 16 bits and writes it back.
- Repeats this over a programmable number of passes, then drains the finished psums on a valid/ready stream toward the next PE row or the global buffer.

Parameters:
- DEPTH, 16, number of psum entries held.
- PSUM_W, 16, stored psum width; equals the PE's SIZEIN.
- ACC_W, 40, PE accumulator width; equals the PE's SIZEOUT.
- PASS_W, 8, width of the pass-count config.
- LEN_W, $clog2(DEPTH+1), width of the length config.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle job start; config is sampled on this cycle.
- cfg_len  in  LEN_W  entries per pass, legal range 1..DEPTH.
- cfg_passes  in  PASS_W  passes per job, legal range 1..2^PASS_W-1.
- busy  out  1  high from accepted start until done.
- mac_vld  in  1  operands a/b presented to the PE this cycle; product registers at the next edge.
- pe_clear  out  1  drives the PE's clear input.
- pe_psum  out  PSUM_W  drives the PE's internal_psum input.
- pe_accum  in  ACC_W  PE's accum_out, signed.
- out_valid  out  1  drain data valid.
- out_ready  in  1  downstream accept.
- out_data  out  PSUM_W  drained psum.
- out_last  out  1  marks the final drained entry.
- done  out  1  one-cycle pulse after the last drain handshake.

Behaviour:
- Reset values: busy=0, pe_clear=0, pe_psum=0, out_valid=0, out_data=0, out_last=0, done=0, FSM=IDLE, idx=0, pass=0.
- Scratchpad is a flop array with no reset. Pass 0 clears every used entry, so its contents never leak into results.
- States: IDLE, ACCUM, DRAIN.
- IDLE: start with cfg_len in 1..DEPTH and cfg_passes≠0 latches len/passes, sets idx=0, pass=0 and goes to ACCUM. Any other start is ignored (busy stays 0).
- start while busy is ignored.
- ACCUM, writeback cycle: the cycle after an accepted mac_vld (wb_vld=registered mac_vld) is the writeback cycle for entry wb_idx (idx at mac_vld time).
  - pe_psum = mem[wb_idx], read combinationally.
  - pe_clear = (pass==0).
  - At the closing edge, mem[wb_idx] <= sat16(pe_accum).
- ACCUM, other cycles: pe_psum=0, pe_clear=0.
- mac_vld may be asserted every cycle, so writebacks stream back-to-back.
  - len=1: the same entry is read one cycle after its write. Flop storage makes this coherent; no bypass is needed.
- idx increments on each accepted mac_vld and wraps len-1 -> 0 with pass++.
- On the mac_vld for idx=len-1 of pass passes-1, further mac_vld is ignored.
- The FSM enters DRAIN on the edge that completes that final writeback.
- mac_vld outside ACCUM (or after the final one) is ignored and causes no writeback.
- sat16: signed clamp of ACC_W to PSUM_W.
  - pe_accum > 32767 -> 32767.
  - pe_accum < -32768 -> -32768.
  - Otherwise the low 16 bits.
- DRAIN is registered-output valid/ready.
  - out_valid=1, out_data=mem[didx], out_last=(didx==len-1).
  - Data is held stable while out_valid & !out_ready.
  - On handshake, didx++ and the next entry is presented the following cycle with no bubble.
  - Handshake with out_last=1: out_valid drops, done=1 for one cycle, busy drops in the same cycle, FSM -> IDLE.
- A new start is accepted in the cycle after done.
- rst_n low mid-job returns immediately to reset values; the partial job is discarded.

Decomposition:
- Shared package pe_pkg holds:
  - localparams SIZEIN=16, SIZEOUT=40, shared with macc.
  - FSM state enum {IDLE, ACCUM, DRAIN}.
  - function sat_psum(acc) returning PSUM_W.
- One sub-module: psum_sat, a combinational ACC_W->PSUM_W clamp, reused later on the external_psum path.
- Scratchpad, FSM and drain stay in psum_spad_ctrl.

Test Plan:
- Single pass: len=4, passes=1, mac_vld 4 back-to-back, pe_accum driven 10,20,30,40 in writeback cycles -> pe_clear=1 in all 4 writeback cycles; drain emits 10,20,30,40 with out_last on 40; done pulses once.
- Multi-pass: len=2, passes=3, bench models the PE (accum = clear?0:psum + prod), prod=5 every op -> pe_psum in pass 2 reads 10,10; drain emits 15,15.
- Saturation: pe_accum = 40'sd100000 then -40'sd70000 -> stored/drained 32767 and -32768.
- len=1, passes=4, mac_vld held high 4 cycles, prod=3 -> pe_psum sequence 0(clear),3,6,9; drain emits 12.
- Backpressure: drain with out_ready toggling 1,0,0,1,… -> out_data stable while stalled; no entry dropped or duplicated; out_last only on entry len-1.
- Illegal/abort: start with cfg_len=0 -> busy stays 0. start mid-ACCUM -> ignored. rst_n low during DRAIN -> out_valid=0 and busy=0 immediately; a fresh job afterwards completes correctly.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: PE widths shared with macc, psum controller states and the psum clamp helper.
package pe_pkg;
  localparam int SIZEIN = 16;
  localparam int SIZEOUT = 40;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  localparam logic signed [SIZEOUT-1:0] PSUM_MAX = {{(SIZEOUT-SIZEIN+1){1'b0}}, {(SIZEIN-1){1'b1}}};
  localparam logic signed [SIZEOUT-1:0] PSUM_MIN = ~PSUM_MAX;
  function automatic logic [SIZEIN-1:0] sat_psum(input logic signed [SIZEOUT-1:0] acc);
    return acc > PSUM_MAX ? PSUM_MAX[SIZEIN-1:0] : acc < PSUM_MIN ? PSUM_MIN[SIZEIN-1:0] : acc[SIZEIN-1:0];
  endfunction
endpackage

// File: rtl/psum_spad_ctrl_if.sv
// psum_stream_if: valid/ready stream carrying drained psums.
interface psum_stream_if #(parameter int W = 16) ();
  logic valid;
  logic ready;
  logic last;
  logic [W-1:0] data;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/psum_sat.sv
// psum_sat: signed clamp of the PE accumulator down to the stored psum width.
module psum_sat import pe_pkg::*; (
  input  logic signed [SIZEOUT-1:0] acc,
  output logic [SIZEIN-1:0] psum
);
  assign psum = sat_psum(acc);
endmodule

// File: rtl/psum_spad_ctrl.sv
// psum_spad_ctrl: psum scratchpad feeding a macc PE over several passes, then draining results.
module psum_spad_ctrl import pe_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int PSUM_W = SIZEIN,
  parameter int ACC_W = SIZEOUT,
  parameter int PASS_W = 8,
  parameter int LEN_W = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [PASS_W-1:0] cfg_passes,
  output logic busy,
  input  logic mac_vld,
  output logic pe_clear,
  output logic [PSUM_W-1:0] pe_psum,
  input  logic signed [ACC_W-1:0] pe_accum,
  output logic done,
  psum_stream_if.master drain
);
  localparam int IW = $clog2(DEPTH);
  state_t state, nxt;
  logic [PSUM_W-1:0] mem [DEPTH];
  logic [IW-1:0] idx, wb_idx, didx;
  logic [LEN_W-1:0] len;
  logic [PASS_W-1:0] pass, passes;
  logic wb_vld, wb_clr, wb_last, go, acc_mac, wrap, fin_mac, hs;
  logic [PSUM_W-1:0] sat_val;
  psum_sat u_sat (.acc(pe_accum), .psum(sat_val));
  // the final op's writeback cycle blocks further ops; the FSM leaves ACCUM at its end
  always_comb begin
    busy = state != IDLE;
    drain.valid = state == DRAIN;
    drain.data = drain.valid ? mem[didx] : '0;
    drain.last = drain.valid && LEN_W'(didx) == len - LEN_W'(1);
    pe_clear = wb_vld && wb_clr;
    pe_psum = wb_vld ? mem[wb_idx] : '0;
    hs = drain.valid && drain.ready;
    go = state == IDLE && start && cfg_len != '0 && cfg_len <= LEN_W'(DEPTH) && cfg_passes != '0;
    acc_mac = state == ACCUM && mac_vld && !(wb_vld && wb_last);
    wrap = LEN_W'(idx) == len - LEN_W'(1);
    fin_mac = wrap && pass == passes - PASS_W'(1);
    nxt = state == IDLE ? (go ? ACCUM : IDLE) :
          state == ACCUM ? (wb_vld && wb_last ? DRAIN : ACCUM) :
          (hs && drain.last ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pass <= '0;
      len <= '0;
      passes <= '0;
      wb_vld <= 1'b0;
      wb_idx <= '0;
      wb_clr <= 1'b0;
      wb_last <= 1'b0;
      didx <= '0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= hs && drain.last;
      wb_vld <= acc_mac;
      if (go) begin
        len <= cfg_len;
        passes <= cfg_passes;
        idx <= '0;
        pass <= '0;
        didx <= '0;
      end
      if (acc_mac) begin
        wb_idx <= idx;
        wb_clr <= pass == '0;
        wb_last <= fin_mac;
        idx <= wrap ? '0 : idx + IW'(1);
        if (wrap) pass <= pass + PASS_W'(1);
      end
      if (hs) didx <= didx + IW'(1);
    end
  always_ff @(posedge clk)
    if (wb_vld) mem[wb_idx] <= sat_val;
endmodule

// File: tb/tb_psum_spad_ctrl.sv
// tb_psum_spad_ctrl: randomized jobs against a PE-plus-scratchpad reference model.
module tb_psum_spad_ctrl;
  logic clk = 0, rst_n = 0, start = 0, mac_vld = 0;
  logic [4:0] cfg_len = '0;
  logic [7:0] cfg_passes = '0;
  logic busy, pe_clear, done;
  logic [15:0] pe_psum;
  logic [39:0] pe_accum = '0;
  int errors = 0, checks = 0;
  int m [16];
  psum_stream_if #(.W(16)) drain ();
  psum_spad_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
    .busy(busy), .mac_vld(mac_vld), .pe_clear(pe_clear), .pe_psum(pe_psum),
    .pe_accum(pe_accum), .done(done), .drain(drain)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  function automatic longint get_prod(input int mode, input int k, input longint cval);
    if (mode == 1) return k % 2 == 0 ? 100000 : -70000;
    if (mode == 2) return cval;
    if (mode == 3) return 10 * (k + 1);
    if ($urandom_range(0, 3) == 0) return longint'($urandom_range(0, 140000)) - 70000;
    return longint'($urandom_range(0, 400)) - 200;
  endfunction

  // vmode 0: mac_vld back-to-back; rmode 0: ready high, 1: 1,0,0 pattern, 2: random
  task automatic run_job(input int len, input int passes, input int mode, input longint cval,
                         input int vmode, input int rmode, input bit mid_start, input bit abort);
    int total, ops, e_q, p_q, d, cyc, we, wp;
    bit pend, wb;
    longint pr_q, wpr, acc;
    total = len * passes; ops = 0; e_q = 0; p_q = 0; d = 0; cyc = 0; pend = 0; pr_q = 0;
    @(posedge clk); #1;
    start = 1; cfg_len = 5'(len); cfg_passes = 8'(passes);
    while (ops < total || pend) begin
      @(posedge clk); #1;
      start = mid_start && cyc == 2;
      if (start) begin cfg_len = 1; cfg_passes = 1; end
      wb = pend; we = e_q; wp = p_q; wpr = pr_q;
      acc = wb ? (wp == 0 ? wpr : m[we] + wpr) : longint'($urandom_range(0, 1000));
      pe_accum = 40'(acc);
      pend = 0;
      mac_vld = ops < total ? (vmode == 0 || $urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      if (mac_vld && ops < total) begin
        pend = 1; e_q = ops % len; p_q = ops / len; pr_q = get_prod(mode, ops, cval); ops++;
      end
      @(negedge clk);
      if (cyc == 0) chk("busy_accum", busy, 1);
      chk("pe_clear", pe_clear, wb && wp == 0);
      if (!(wb && wp == 0)) chk("pe_psum", $signed(pe_psum), wb ? m[we] : 0);
      if (wb) m[we] = int'(sat(acc));
      cyc++;
    end
    start = 0; cyc = 0;
    while (d < len && cyc < 200) begin
      @(posedge clk); #1;
      drain.ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      mac_vld = 1'($urandom_range(0, 1));
      if (abort && d == 1) begin
        rst_n = 0; #1;
        chk("abort_valid", drain.valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        #2; rst_n = 1; mac_vld = 0; drain.ready = 0;
        return;
      end
      @(negedge clk);
      chk("out_valid", drain.valid, 1);
      chk("out_data", $signed(drain.data), m[d]);
      chk("out_last", drain.last, d == len - 1);
      chk("pe_clear_drain", pe_clear, 0);
      if (drain.ready) d++;
      cyc++;
    end
    if (d < len) chk("drain_timeout", d, len);
    @(posedge clk); #1;
    drain.ready = 0; mac_vld = 0;
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", drain.valid, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int bad_len [3] = '{0, 17, 4};
    int bad_pass [3] = '{1, 1, 0};
    drain.ready = 0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", pe_clear, 0);
    chk("rst_psum", pe_psum, 0);
    chk("rst_valid", drain.valid, 0);
    chk("rst_data", drain.data, 0);
    chk("rst_last", drain.last, 0);
    #10; rst_n = 1;
    run_job(4, 1, 3, 0, 0, 0, 0, 0);
    run_job(2, 3, 2, 5, 0, 0, 0, 0);
    run_job(2, 1, 1, 0, 0, 0, 0, 0);
    run_job(1, 4, 2, 3, 0, 0, 0, 0);
    run_job(5, 2, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1; cfg_len = 5'(bad_len[i]); cfg_passes = 8'(bad_pass[i]);
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      chk("illegal_start", busy, 0);
    end
    run_job(3, 2, 0, 0, 1, 2, 1, 0);
    run_job(4, 2, 0, 0, 0, 2, 0, 1);
    run_job(3, 2, 0, 0, 1, 1, 0, 0);
    run_job(16, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run_job($urandom_range(1, 16), $urandom_range(1, 4), 0, 0, 1, 2, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
